// File: rtl/sys_bus_router.sv
// -----------------------------------------------------------------------------
// sys_bus_router
// Single-master, N-slave peripheral router between the core LSU memory port and
// memory-mapped slaves. addr[31:24] selects a slave through a base table; the
// selected slave gets a one-cycle request strobe and the router waits for its
// ready. The response to the LSU is registered. Unmapped addresses and slaves
// that never answer produce an error response (ERR_DATA, err_o pulse). The
// faulting address and a saturating error count are recorded.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   mem_req_i/we/be/addr/wd  LSU request, held stable until mem_ready_o
//   mem_rd_o, mem_ready_o  registered read data, one-cycle response strobe
//   slv_req_o              one-hot request strobe (one cycle, IDLE only)
//   slv_we/be/addr/wd_o    request fields passed through (addr top byte zeroed)
//   slv_rd_i, slv_ready_i  per-slave read data (32 bits each) and ready
//   err_o                  one-cycle pulse with an error response
//   err_addr_o, err_cnt_o  last faulting address, saturating error count
// -----------------------------------------------------------------------------
module sys_bus_router #(
  parameter int unsigned             N_SLAVES   = 3,
  parameter logic [N_SLAVES*8-1:0]   SLAVE_BASE = {8'h07, 8'h03, 8'h00},
  parameter int unsigned             TIMEOUT    = 64,
  parameter logic [31:0]             ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mem_req_i,
  input  logic                     mem_we_i,
  input  logic [3:0]               mem_be_i,
  input  logic [31:0]              mem_addr_i,
  input  logic [31:0]              mem_wd_i,
  output logic [31:0]              mem_rd_o,
  output logic                     mem_ready_o,
  output logic [N_SLAVES-1:0]      slv_req_o,
  output logic                     slv_we_o,
  output logic [3:0]               slv_be_o,
  output logic [31:0]              slv_addr_o,
  output logic [31:0]              slv_wd_o,
  input  logic [N_SLAVES*32-1:0]   slv_rd_i,
  input  logic [N_SLAVES-1:0]      slv_ready_i,
  output logic                     err_o,
  output logic [31:0]              err_addr_o,
  output logic [15:0]              err_cnt_o
);

  localparam int TCNT_W = $clog2(TIMEOUT);
  localparam int SEL_W  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
  logic [31:0]        rd_q, rd_d;
  logic               err_q, err_d;
  logic [31:0]        err_addr_q, err_addr_d;
  logic [15:0]        err_cnt_q, err_cnt_d;

  // Per-slave views of the flat read-data bus and the decode hits.
  logic [31:0]         rd_arr [N_SLAVES];
  logic [N_SLAVES-1:0] hit;
  logic                hit_any;
  logic [SEL_W-1:0]    hit_idx;

  for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_slave
    assign rd_arr[gi] = slv_rd_i[32*gi +: 32];
    assign hit[gi]    = (mem_addr_i[31:24] == SLAVE_BASE[8*gi +: 8]);
  end

  // Scan from the top down so the lowest matching slot is the one left.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      if (hit[k]) begin
        hit_any = 1'b1;
        hit_idx = SEL_W'(k);
      end
    end
  end

  // Combinational pass-through of the request fields.
  assign slv_we_o   = mem_we_i;
  assign slv_be_o   = mem_be_i;
  assign slv_addr_o = {8'h00, mem_addr_i[23:0]};
  assign slv_wd_o   = mem_wd_i;

  assign mem_ready_o = (state_q == ST_RESP);
  assign mem_rd_o    = rd_q;
  assign err_o       = (state_q == ST_RESP) && err_q;
  assign err_addr_o  = err_addr_q;
  assign err_cnt_o   = err_cnt_q;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    tcnt_d     = tcnt_q;
    rd_d       = rd_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    slv_req_o  = '0;

    case (state_q)
      ST_IDLE: begin
        if (mem_req_i) begin
          if (hit_any) begin
            // Strobe is gated by reset so nothing leaks out while rst_i is high.
            slv_req_o = rst_i ? '0 : (N_SLAVES'(1) << hit_idx);
            sel_d     = hit_idx;
            if (slv_ready_i[hit_idx]) begin
              rd_d    = rd_arr[hit_idx];
              state_d = ST_RESP;
            end else begin
              tcnt_d  = '0;
              state_d = ST_WAIT;
            end
          end else begin
            rd_d       = ERR_DATA;
            err_d      = 1'b1;
            err_addr_d = mem_addr_i;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            state_d    = ST_RESP;
          end
        end
      end

      ST_WAIT: begin
        // Ready wins over an expiring timeout in the same cycle.
        if (slv_ready_i[sel_q]) begin
          rd_d    = rd_arr[sel_q];
          state_d = ST_RESP;
        end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
          rd_d       = ERR_DATA;
          err_d      = 1'b1;
          err_addr_d = mem_addr_i;
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          state_d    = ST_RESP;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      tcnt_q     <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      tcnt_q     <= tcnt_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: doc/sys_bus_router.md
# sys_bus_router

Parametrised single-master, N-slave peripheral router between the core LSU memory port and the memory-mapped slaves (data memory, PS/2, VGA, and later UART, switches, LEDs, hex display). It decodes `addr[31:24]` against a per-slave base table and forwards a one-cycle request strobe to the selected slave. It then waits for that slave's `ready` and returns a registered read/ready response to the LSU. Unmapped addresses and slaves that never answer produce an error response, so the core cannot hang. A faulting-address register and a saturating error counter record every error.

## Interface
- `N_SLAVES`, default 3: number of slave channels (1..16).
- `SLAVE_BASE`, default {8'h07, 8'h03, 8'h00}: packed `N_SLAVES*8` table; slot k (bits `[8k+7:8k]`) is the `addr[31:24]` value of slave k.
- `TIMEOUT`, default 64: number of WAIT cycles before an error response (at least 2).
- `ERR_DATA`, default 32'hDEAD_BEEF: read data returned on any error response.

Ports:
- `clk_i` in 1: system clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `mem_req_i` in 1: LSU request. The LSU holds this and all request fields stable until `mem_ready_o`.
- `mem_we_i` in 1: write enable.
- `mem_be_i` in 4: byte enables.
- `mem_addr_i` in 32: byte address.
- `mem_wd_i` in 32: write data.
- `mem_rd_o` out 32: registered read data.
- `mem_ready_o` out 1: one-cycle response strobe.
- `slv_req_o` out N_SLAVES: one-hot request strobe.
- `slv_we_o` out 1: `mem_we_i` passed through.
- `slv_be_o` out 4: `mem_be_i` passed through.
- `slv_addr_o` out 32: `{8'h00, mem_addr_i[23:0]}`.
- `slv_wd_o` out 32: `mem_wd_i` passed through.
- `slv_rd_i` in N_SLAVES*32: slave read data; slave k uses bits `[32k+31:32k]`.
- `slv_ready_i` in N_SLAVES: slave ready signals.
- `err_o` out 1: one-cycle pulse, coincident with an error response.
- `err_addr_o` out 32: address of the most recent error.
- `err_cnt_o` out 16: count of errors, saturating at 16'hFFFF.

## Operation
- Decode: `hit_k = (mem_addr_i[31:24] == SLAVE_BASE[8k+7:8k])`. If several slots match, the lowest k wins. If none match, the access is a miss.
- The FSM has three states: IDLE, WAIT, RESP.
- IDLE, `mem_req_i`=0: the FSM stays in IDLE and all `slv_req_o` are 0.
- IDLE, `mem_req_i`=1, hit on slave k:
  - `slv_req_o[k]`=1 (combinational, this cycle only).
  - The router latches `sel`=k.
  - If `slv_ready_i[k]`=1 in the same cycle, it captures `slv_rd_i[k]` into `rd_q` and moves to RESP.
  - Otherwise it clears `tcnt` and moves to WAIT.
- IDLE, `mem_req_i`=1, miss:
  - No `slv_req_o` is asserted.
  - `rd_q`=ERR_DATA, the error flag is set, `err_addr_o` takes `mem_addr_i`, and the FSM moves to RESP.
- WAIT:
  - `slv_req_o` is all 0; the request is a single-pulse handshake.
  - On `slv_ready_i[sel]`=1: `rd_q` takes `slv_rd_i[sel]`, then RESP.
  - Otherwise `tcnt` increments. When `tcnt` reaches TIMEOUT-1 with no ready: `rd_q`=ERR_DATA, error flag set, `err_addr_o` takes `mem_addr_i`, then RESP.
  - `slv_ready_i` from non-selected slaves is ignored.
- RESP:
  - `mem_ready_o`=1 and `mem_rd_o`=`rd_q`; `err_o`=1 if the error flag is set.
  - The FSM returns to IDLE unconditionally and the error flag clears.
  - `mem_req_i` is not sampled in RESP; a back-to-back request is accepted in the following IDLE cycle.
- `err_cnt_o` increments once per error response and saturates at 16'hFFFF.
- Writes follow the same flow. `mem_rd_o` on a write response is the selected slave's `rd` (don't-care to the LSU), or ERR_DATA on an error.
- `tcnt` width is `$clog2(TIMEOUT)`.

## Timing
- Reset (asynchronous, any state):
  - FSM returns to IDLE, `mem_ready_o`=0, `mem_rd_o`=0, `err_o`=0, `err_addr_o`=0, `err_cnt_o`=0, `sel`=0, `tcnt`=0.
  - `slv_req_o`=0 while `rst_i`=1.
  - An access in flight when reset hits is dropped with no response. A late `slv_ready_i` after reset is ignored (the FSM is in IDLE and no request is outstanding).
- Latency, with request in IDLE at cycle 0:
  - Slave ready in cycle 0: `mem_ready_o` in cycle 1.
  - Slave ready in cycle n (n≥1): `mem_ready_o` in cycle n+1.
  - Miss: `mem_ready_o` and `err_o` in cycle 1.
  - Timeout: `mem_ready_o` and `err_o` in cycle TIMEOUT+1.
- Throughput: at most one access per 2 cycles.
- `slv_we_o`, `slv_be_o`, `slv_addr_o` and `slv_wd_o` are combinational pass-throughs, valid whenever the master holds its request.
- Ready arriving in the same cycle the timeout expires counts as success (ready has priority).

## Test plan
- Defaults, read 32'h0000_0010; data memory gives ready in the same cycle with rd=32'h1234_5678. Required: `slv_req_o`=3'b001 for one cycle, `mem_ready_o` in cycle 1, `mem_rd_o`=32'h1234_5678, `err_o`=0.
- Read 32'h0700_0004; VGA gives ready 3 cycles after the request with rd=32'hA5. Required: `slv_req_o`=3'b100 in cycle 0 only, `slv_addr_o`=32'h0000_0004, `mem_ready_o` in cycle 4 with `mem_rd_o`=32'hA5. PS/2 ready toggling during WAIT is ignored.
- Access to 32'h0500_0000 (unmapped). Required: no `slv_req_o`, `mem_ready_o`=1 and `err_o`=1 in cycle 1, `mem_rd_o`=32'hDEAD_BEEF, `err_addr_o`=32'h0500_0000, `err_cnt_o`=1.
- TIMEOUT=8, write to 32'h0300_0000, PS/2 never ready. Required: response in cycle 9 with `err_o`=1 and `err_cnt_o` incremented. Repeat with ready in exactly the final WAIT cycle: no error.
- Assert `rst_i` in mid-WAIT, then fire slave ready after release. Required: all outputs are 0 immediately, no `mem_ready_o`, FSM in IDLE, and the next request is served normally.
- Parameterise N_SLAVES=5 with a duplicate base in slots 1 and 3. Required: slave 1 is selected. Force 65540 misses: `err_cnt_o` holds at 16'hFFFF.
